// File: rtl/rob_alloc_commit_if.sv
// ROB-init booking channel between the register manager (master) and the
// reorder buffer (slave).
//   alloc_valid    master -> slave  booking request
//   alloc_ready    slave  -> master booking accepted when high with valid
//   alloc_wr       master -> slave  entry writes a destination register
//   alloc_areg     master -> slave  architectural destination
//   alloc_preg_new master -> slave  newly mapped physical register
//   alloc_preg_old master -> slave  previous mapping, freed at commit
//   alloc_direc    master -> slave  commit director (00 NORMAL, 01 FLUSH, 10 HALT)
//   alloc_done     master -> slave  entry complete at booking
//   alloc_tag      slave  -> master tag assigned to the current booking
interface rob_alloc_commit_if #(
  parameter int ENTRIES = 16,
  parameter int AREG_W  = 5,
  parameter int PREG_W  = 6,
  parameter int TAG_W   = $clog2(ENTRIES)
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_wr;
  logic [AREG_W-1:0] alloc_areg;
  logic [PREG_W-1:0] alloc_preg_new;
  logic [PREG_W-1:0] alloc_preg_old;
  logic [1:0]        alloc_direc;
  logic              alloc_done;
  logic [TAG_W-1:0]  alloc_tag;

  modport master (
    output alloc_valid, alloc_wr, alloc_areg, alloc_preg_new, alloc_preg_old,
           alloc_direc, alloc_done,
    input  alloc_ready, alloc_tag
  );

  modport slave (
    input  alloc_valid, alloc_wr, alloc_areg, alloc_preg_new, alloc_preg_old,
           alloc_direc, alloc_done,
    output alloc_ready, alloc_tag
  );
endinterface

// File: rtl/rob_alloc_commit.sv
// Reorder-buffer allocation and in-order commit engine.
//   clk, rst_n      clock, asynchronous active-low reset
//   alloc           booking channel (slave end), returns tag = tail index
//   cmpl_valid/tag  completion broadcast; marks a valid entry done
//   cmt_*           registered record of the entry retired at the last edge
//   flush           registered pulse: younger entries discarded
//   halted          sticky, set by a HALT retirement
//   count           occupied entries
module rob_alloc_commit #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = $clog2(ENTRIES),
  parameter int AREG_W  = 5,
  parameter int PREG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  rob_alloc_commit_if.slave alloc,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  output logic              cmt_valid,
  output logic              cmt_wr,
  output logic [AREG_W-1:0] cmt_areg,
  output logic [PREG_W-1:0] cmt_preg_new,
  output logic [PREG_W-1:0] cmt_preg_old,
  output logic              flush,
  output logic              halted,
  output logic [TAG_W:0]    count
);

  localparam logic [1:0] DIREC_FLUSH = 2'b01;
  localparam logic [1:0] DIREC_HALT  = 2'b10;

  logic [TAG_W:0]     head, tail;
  logic [TAG_W-1:0]   head_idx, tail_idx;
  logic [ENTRIES-1:0] ent_valid, ent_done;

  logic              ent_wr       [ENTRIES];
  logic [AREG_W-1:0] ent_areg     [ENTRIES];
  logic [PREG_W-1:0] ent_preg_new [ENTRIES];
  logic [PREG_W-1:0] ent_preg_old [ENTRIES];
  logic [1:0]        ent_direc    [ENTRIES];

  logic full, head_rdy, commit_fire, flush_now, do_flush, alloc_fire;

  always_comb begin
    head_idx    = head[TAG_W-1:0];
    tail_idx    = tail[TAG_W-1:0];
    full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    head_rdy    = ent_valid[head_idx] && ent_done[head_idx];
    flush_now   = head_rdy && (ent_direc[head_idx] == DIREC_FLUSH);
    commit_fire = !halted && head_rdy;
    do_flush    = commit_fire && flush_now;
    alloc_fire  = alloc.alloc_valid && alloc.alloc_ready;
    count       = tail - head;
  end

  assign alloc.alloc_ready = !full && !halted && !flush_now;
  assign alloc.alloc_tag   = tail_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      ent_valid    <= '0;
      ent_done     <= '0;
      cmt_valid    <= 1'b0;
      cmt_wr       <= 1'b0;
      cmt_areg     <= '0;
      cmt_preg_new <= '0;
      cmt_preg_old <= '0;
      flush        <= 1'b0;
      halted       <= 1'b0;
    end else begin
      cmt_valid <= commit_fire;
      flush     <= do_flush;

      // Completion uses the pre-edge valid bit, so a same-cycle booking of
      // the target entry does not pick it up.
      if (cmpl_valid && ent_valid[cmpl_tag] && !do_flush)
        ent_done[cmpl_tag] <= 1'b1;

      if (alloc_fire) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_done[tail_idx]  <= alloc.alloc_done;
        tail                <= tail + 1'b1;
      end

      if (commit_fire) begin
        cmt_wr              <= ent_wr[head_idx];
        cmt_areg            <= ent_areg[head_idx];
        cmt_preg_new        <= ent_preg_new[head_idx];
        cmt_preg_old        <= ent_preg_old[head_idx];
        ent_valid[head_idx] <= 1'b0;
        head                <= head + 1'b1;
        if (flush_now) begin
          // Booking is blocked while flush_now, so no tail write conflicts.
          ent_valid <= '0;
          tail      <= head + 1'b1;
        end
        if (ent_direc[head_idx] == DIREC_HALT)
          halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_wr[tail_idx]       <= alloc.alloc_wr;
      ent_areg[tail_idx]     <= alloc.alloc_areg;
      ent_preg_new[tail_idx] <= alloc.alloc_preg_new;
      ent_preg_old[tail_idx] <= alloc.alloc_preg_old;
      ent_direc[tail_idx]    <= alloc.alloc_direc;
    end
  end

endmodule

// File: tb/tb_rob_alloc_commit.sv
// Directed self-checking bench for rob_alloc_commit.
module tb_rob_alloc_commit;

  localparam int ENTRIES = 16;
  localparam int TAG_W   = 4;
  localparam int AREG_W  = 5;
  localparam int PREG_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmpl_valid = 1'b0;
  logic [TAG_W-1:0]  cmpl_tag = '0;
  logic              cmt_valid, cmt_wr, flush, halted;
  logic [AREG_W-1:0] cmt_areg;
  logic [PREG_W-1:0] cmt_preg_new, cmt_preg_old;
  logic [TAG_W:0]    count;

  int total = 0;
  int bad   = 0;

  rob_alloc_commit_if #(.ENTRIES(ENTRIES), .AREG_W(AREG_W), .PREG_W(PREG_W)) bus ();

  rob_alloc_commit #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .AREG_W(AREG_W), .PREG_W(PREG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc        (bus),
    .cmpl_valid   (cmpl_valid),
    .cmpl_tag     (cmpl_tag),
    .cmt_valid    (cmt_valid),
    .cmt_wr       (cmt_wr),
    .cmt_areg     (cmt_areg),
    .cmt_preg_new (cmt_preg_new),
    .cmt_preg_old (cmt_preg_old),
    .flush        (flush),
    .halted       (halted),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    cmpl_valid      = 1'b0;
  endtask

  task automatic book(input logic [1:0] direc, input logic done,
                      input logic [AREG_W-1:0] areg,
                      input logic [PREG_W-1:0] pnew, input logic [PREG_W-1:0] pold);
    bus.alloc_valid    = 1'b1;
    bus.alloc_wr       = 1'b1;
    bus.alloc_direc    = direc;
    bus.alloc_done     = done;
    bus.alloc_areg     = areg;
    bus.alloc_preg_new = pnew;
    bus.alloc_preg_old = pold;
  endtask

  task automatic cmpl(input logic [TAG_W-1:0] t);
    cmpl_valid = 1'b1;
    cmpl_tag   = t;
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst_n = 1'b0;
    #1;
    chk({tag, "_count"}, count, 0);
    chk({tag, "_tag"}, bus.alloc_tag, 0);
    chk({tag, "_ready"}, bus.alloc_ready, 1);
    chk({tag, "_cmtv"}, cmt_valid, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_pold"}, cmt_preg_old, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.alloc_valid = 1'b0;
    bus.alloc_wr = 1'b0;
    bus.alloc_areg = '0;
    bus.alloc_preg_new = '0;
    bus.alloc_preg_old = '0;
    bus.alloc_direc = 2'b00;
    bus.alloc_done = 1'b0;

    // ---- reset state, three bookings, out-of-order completion ----
    #2;
    do_reset("rst0");
    for (int i = 0; i < 3; i++) begin
      book(2'b00, 1'b0, 5'(i + 1), 6'(20 + i), 6'(10 + i));
      chk("t1_tag", bus.alloc_tag, i);
      chk("t1_ready", bus.alloc_ready, 1);
      tick();
    end
    idle();
    chk("t1_count3", count, 3);
    cmpl(4'd2); tick(); idle();
    chk("t1_no_cmt_a", cmt_valid, 0);
    cmpl(4'd0); tick();
    chk("t1_no_cmt_b", cmt_valid, 0);
    cmpl(4'd1); tick(); idle();
    chk("t1_cmt0_v", cmt_valid, 1);
    chk("t1_cmt0_old", cmt_preg_old, 10);
    chk("t1_cmt0_new", cmt_preg_new, 20);
    chk("t1_cmt0_areg", cmt_areg, 1);
    chk("t1_cmt0_wr", cmt_wr, 1);
    tick();
    chk("t1_cmt1_v", cmt_valid, 1);
    chk("t1_cmt1_old", cmt_preg_old, 11);
    tick();
    chk("t1_cmt2_v", cmt_valid, 1);
    chk("t1_cmt2_old", cmt_preg_old, 12);
    tick();
    chk("t1_idle_v", cmt_valid, 0);
    chk("t1_count0", count, 0);

    // ---- full ROB, stalled 17th booking ----
    do_reset("rst1");
    for (int i = 0; i < 16; i++) begin
      book(2'b00, 1'b0, 5'(i), 6'(i), 6'(32 + i));
      tick();
    end
    book(2'b00, 1'b0, 5'd17, 6'd17, 6'd50);
    chk("t2_count16", count, 16);
    chk("t2_ready0", bus.alloc_ready, 0);
    tick();
    chk("t2_stall_count", count, 16);
    chk("t2_stall_ready", bus.alloc_ready, 0);
    cmpl(4'd0); tick(); cmpl_valid = 1'b0;
    chk("t2_full_after_cmpl", count, 16);
    tick();
    chk("t2_cmt_v", cmt_valid, 1);
    chk("t2_cmt_old", cmt_preg_old, 32);
    chk("t2_count15", count, 15);
    chk("t2_ready1", bus.alloc_ready, 1);
    chk("t2_tag0", bus.alloc_tag, 0);
    tick(); idle();
    chk("t2_regrant_count", count, 16);
    chk("t2_regrant_ready", bus.alloc_ready, 0);
    chk("t2_no_cmt", cmt_valid, 0);

    // ---- flush director; reset here also discards a full ROB ----
    do_reset("rst2");
    for (int i = 0; i < 6; i++) begin
      book((i == 2) ? 2'b01 : 2'b00, 1'b0, 5'(i), 6'(i + 8), 6'(i));
      tick();
    end
    idle();
    cmpl(4'd0); tick();
    cmpl(4'd1); tick();
    chk("t3_cmt0_v", cmt_valid, 1);
    chk("t3_cmt0_old", cmt_preg_old, 0);
    chk("t3_cmt0_fl", flush, 0);
    cmpl(4'd2); tick();
    chk("t3_cmt1_old", cmt_preg_old, 1);
    cmpl(4'd3); tick();
    chk("t3_cmt2_v", cmt_valid, 1);
    chk("t3_cmt2_old", cmt_preg_old, 2);
    chk("t3_flush", flush, 1);
    chk("t3_count0", count, 0);
    cmpl(4'd4); tick();
    chk("t3_flush_off", flush, 0);
    chk("t3_no_cmt4", cmt_valid, 0);
    cmpl(4'd5); tick(); idle();
    chk("t3_no_cmt5", cmt_valid, 0);
    tick();
    chk("t3_no_cmt_late", cmt_valid, 0);
    chk("t3_next_tag", bus.alloc_tag, 3);
    book(2'b00, 1'b0, 5'd0, 6'd0, 6'd0);
    tick(); idle();
    chk("t3_count1", count, 1);

    // ---- halt director ----
    do_reset("rst3");
    book(2'b10, 1'b1, 5'd3, 6'd9, 6'd7);
    tick(); idle();
    chk("t4_no_cmt_yet", cmt_valid, 0);
    tick();
    chk("t4_cmt_v", cmt_valid, 1);
    chk("t4_cmt_old", cmt_preg_old, 7);
    chk("t4_halted", halted, 1);
    chk("t4_ready0", bus.alloc_ready, 0);
    book(2'b00, 1'b1, 5'd4, 6'd4, 6'd4);
    cmpl(4'd1);
    for (int i = 0; i < 3; i++) tick();
    idle();
    chk("t4_hold_count", count, 0);
    chk("t4_hold_cmtv", cmt_valid, 0);
    chk("t4_hold_halted", halted, 1);
    chk("t4_hold_tag", bus.alloc_tag, 1);
    do_reset("rst4");

    // ---- stale completion to an empty slot ----
    cmpl(4'd5); tick(); idle();
    for (int i = 0; i < 6; i++) begin
      book(2'b00, (i < 5) ? 1'b1 : 1'b0, 5'(i), 6'(i), 6'(40 + i));
      tick();
    end
    idle();
    chk("t5_cmt4_old", cmt_preg_old, 44);
    tick();
    chk("t5_stuck_v", cmt_valid, 0);
    chk("t5_stuck_count", count, 1);
    tick();
    chk("t5_stuck_v2", cmt_valid, 0);
    cmpl(4'd5); tick(); idle();
    chk("t5_done_no_cmt", cmt_valid, 0);
    tick();
    chk("t5_cmt5_v", cmt_valid, 1);
    chk("t5_cmt5_old", cmt_preg_old, 45);
    chk("t5_count0", count, 0);

    // ---- sustained traffic across the tag wrap ----
    do_reset("rst5");
    for (int i = 0; i < 40; i++) begin
      book(2'b00, 1'b1, 5'(i), 6'(i), 6'((i * 3) % 64));
      chk("t6_tag", bus.alloc_tag, i % 16);
      chk("t6_ready", bus.alloc_ready, 1);
      tick();
      chk("t6_count", count, 1);
      if (i == 0) begin
        chk("t6_first_cmtv", cmt_valid, 0);
      end else begin
        chk("t6_cmtv", cmt_valid, 1);
        chk("t6_old", cmt_preg_old, ((i - 1) * 3) % 64);
      end
    end
    idle();
    tick();
    chk("t6_last_old", cmt_preg_old, (39 * 3) % 64);
    chk("t6_drain_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
